mem_access: RTL and testbench
=============================

# mem_access

MEM-stage data-memory access unit for the five-stage MIPS pipeline. It consumes the MEM/WB control bundle the decode controller issues (MEMWr, MEMOp, loadSignExt, WBSel, RFWr, mux_WBData) plus the EX result. It drives a req/ack data-memory port with byte-lane alignment and extracts and extends load data. It holds the pipeline via `stall` while memory is busy and registers the write-back bundle for the WB stage.

## Interface
- ACK_TIMEOUT, 255: max WAIT cycles before the access is aborted.
- TO_W, 8: timeout counter width; must hold ACK_TIMEOUT.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- MEMWr_in  in  1  store request
- MEMOp_in  in  2  access size (`MEMOP_WORD/HALFWORD/BYTE` from def.v)
- loadSignExt_in  in  1  1 = sign-extend sub-word load
- mux_WBData_in  in  2  `WBDATA_ALU/MEM/PCPLUS4`; MEM with MEMWr_in=0 = load
- WBSel_in  in  5  destination register
- RFWr_in  in  1  register write enable
- addr_in  in  32  ALU result (effective address or ALU value)
- store_data_in  in  32  rt value
- pc_plus4_in  in  32  link value
- dm_req  out  1  memory request
- dm_we  out  1  write strobe
- dm_be  out  4  byte enables, bit0 = byte at addr[1:0]=0 (little-endian)
- dm_addr  out  32  {addr_in[31:2],2'b00}
- dm_wdata  out  32  lane-replicated store data
- dm_rdata  in  32  read data, valid when dm_ack=1
- dm_ack  in  1  access complete
- stall  out  1  freeze IF/ID/EX and the EX/MEM register
- wb_data  out  32  registered write-back data
- wb_sel  out  5  registered WBSel
- wb_RFWr  out  1  registered RFWr
- addr_err  out  1  one-cycle misalignment flag (combinational)
- bus_err  out  1  one-cycle timeout flag (registered)

## Operation
- access = MEMWr_in | (mux_WBData_in==`WBDATA_MEM`). misaligned = half with addr_in[0]=1, or word with addr_in[1:0]!=0.
- FSM states IDLE, WAIT. Transitions:
  - IDLE, access & !misaligned & !dm_ack: go to WAIT.
  - WAIT & dm_ack: go to IDLE.
  - WAIT & count==ACK_TIMEOUT: go to IDLE and set bus_err for one cycle.
- dm_req = !rst & !misaligned & access & (IDLE|WAIT); it is asserted from the first cycle of the access. dm_we = dm_req & MEMWr_in.
- stall = dm_req & !dm_ack & !timeout_hit. Inputs are held stable by the pipeline while stall=1.
- Store lanes:
  - byte: wdata={4{b}}, be=4'b0001<<addr[1:0].
  - half: wdata={2{h}}, be=4'b0011<<{addr[1],1'b0}.
  - word: be=4'b1111.
- Load extraction: byte selected by addr[1:0], half by addr[1]. Extend per loadSignExt_in; word loads ignore it.
- WB register loads when !stall:
  - wb_sel <= WBSel_in.
  - wb_RFWr <= RFWr_in & !misaligned & !timeout_hit.
  - wb_data <= ALU: addr_in; MEM: extracted dm_rdata; PCPLUS4: pc_plus4_in.
- Misaligned access: no dm_req, no stall, addr_err=1 that cycle, wb_RFWr=0.

## Timing
- Reset values: state IDLE, count 0, wb_data 0, wb_sel 0, wb_RFWr 0, bus_err 0. dm_req, stall and dm_we are forced 0 while rst=1.
- Non-access instruction: wb_* valid one clock after the inputs, stall never asserted.
- Zero-wait memory (dm_ack in the same cycle as dm_req): no stall, one-cycle latency.
- N-cycle ack: stall is high for N cycles. wb_* update on the edge of the ack cycle.
- Counter: cleared in IDLE, increments each WAIT cycle.
- Ack on the same cycle as timeout: ack wins, normal completion, no bus_err.
- rst during WAIT: FSM returns to IDLE and wb_RFWr=0 next edge. The pending access is dropped, not replayed.
- Back-to-back accesses: the next request can start the cycle after an ack (IDLE re-entry). There are no idle gaps besides memory wait.

## Test plan
- SB, addr 0x1003, rt=0x000000A5, ack same cycle -> be=4'b1000, wdata=0xA5A5A5A5, dm_addr=0x1000, stall never 1.
- LH, addr 0x2002, loadSignExt=1, rdata=0x80017FFF, ack after 3 cycles -> stall high 3 cycles, then wb_data=0xFFFF8001, wb_RFWr=1.
- LBU, addr 0x2001, rdata=0x0000F000 -> wb_data=0x000000F0. LB on the same data -> 0xFFFFFFF0.
- LW, addr 0x3002 -> addr_err=1 one cycle, dm_req=0, wb_RFWr=0, no stall.
- SW, dm_ack held 0, ACK_TIMEOUT=4 -> stall for 4 wait cycles, then bus_err pulse, wb_RFWr=0, FSM in IDLE. Repeat with ack on the timeout cycle -> no bus_err.
- ADDU then JAL (mux_WBData_in=PCPLUS4, pc_plus4_in=0x0040000C), with rst pulsed during a waiting load -> wb_data=addr_in, then 0x0040000C. Reset returns dm_req=0 and wb_RFWr=0.

Source files
------------

// File: rtl/mem_access.sv
// MEM-stage data-memory access unit: req/ack memory port with byte-lane
// alignment, load extraction/extension, pipeline stall and WB registers.
module mem_access #(
    parameter int ACK_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEMWr_in,
    input  logic [1:0]  MEMOp_in,
    input  logic        loadSignExt_in,
    input  logic [1:0]  mux_WBData_in,
    input  logic [4:0]  WBSel_in,
    input  logic        RFWr_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic [31:0] pc_plus4_in,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stall,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_sel,
    output logic        wb_RFWr,
    output logic        addr_err,
    output logic        bus_err
);
    // Encodings shared with the decode controller
    localparam logic [1:0] MEMOP_WORD     = 2'b00;
    localparam logic [1:0] MEMOP_HALFWORD = 2'b01;
    localparam logic [1:0] MEMOP_BYTE     = 2'b10;
    localparam logic [1:0] WBDATA_ALU     = 2'b00;
    localparam logic [1:0] WBDATA_MEM     = 2'b01;
    localparam logic [1:0] WBDATA_PCPLUS4 = 2'b10;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(ACK_TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state_q;
    logic [TO_W-1:0] count_q;
    logic            bus_err_q;
    logic [31:0]     wb_data_q;
    logic [4:0]      wb_sel_q;
    logic            wb_RFWr_q;

    logic        access;
    logic        misaligned;
    logic        timeout_hit;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] rd_shift;
    logic [31:0] load_d;

    assign access   = MEMWr_in | (mux_WBData_in == WBDATA_MEM);
    assign rd_shift = dm_rdata >> {addr_in[1:0], 3'b000};

    // Size decode: lane enables, replicated store data, extracted load data
    always_comb begin
        be_d       = 4'b1111;
        wdata_d    = store_data_in;
        load_d     = dm_rdata;
        misaligned = 1'b0;
        case (MEMOp_in)
            MEMOP_BYTE: begin
                be_d    = 4'b0001 << addr_in[1:0];
                wdata_d = {4{store_data_in[7:0]}};
                load_d  = {{24{loadSignExt_in & rd_shift[7]}}, rd_shift[7:0]};
            end
            MEMOP_HALFWORD: begin
                be_d       = 4'b0011 << {addr_in[1], 1'b0};
                wdata_d    = {2{store_data_in[15:0]}};
                load_d     = {{16{loadSignExt_in & rd_shift[15]}}, rd_shift[15:0]};
                misaligned = access & addr_in[0];
            end
            default: begin
                misaligned = access & (addr_in[1:0] != 2'b00);
            end
        endcase
    end

    // Ack beats the timeout when both land in the same cycle
    assign timeout_hit = (state_q == WAIT) && (count_q == TO_MAX) && !dm_ack;

    assign dm_req   = !rst & !misaligned & access;
    assign dm_we    = dm_req & MEMWr_in;
    assign dm_be    = dm_req ? be_d : 4'b0000;
    assign dm_addr  = {addr_in[31:2], 2'b00};
    assign dm_wdata = wdata_d;
    assign stall    = dm_req & !dm_ack & !timeout_hit;
    assign addr_err = misaligned;
    assign bus_err  = bus_err_q;
    assign wb_data  = wb_data_q;
    assign wb_sel   = wb_sel_q;
    assign wb_RFWr  = wb_RFWr_q;

    // Access FSM with wait counter and registered timeout pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    count_q <= '0;
                    if (dm_req && !dm_ack) state_q <= WAIT;
                end
                WAIT: begin
                    if (dm_ack) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else if (count_q == TO_MAX) begin
                        state_q   <= IDLE;
                        count_q   <= '0;
                        bus_err_q <= 1'b1;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write-back register advances whenever the pipeline is not held
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data_q <= '0;
            wb_sel_q  <= '0;
            wb_RFWr_q <= 1'b0;
        end else if (!stall) begin
            wb_sel_q  <= WBSel_in;
            wb_RFWr_q <= RFWr_in & !misaligned & !timeout_hit;
            case (mux_WBData_in)
                WBDATA_MEM:     wb_data_q <= load_d;
                WBDATA_PCPLUS4: wb_data_q <= pc_plus4_in;
                default:        wb_data_q <= addr_in;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: expected WB results are queued when an
// instruction is driven and compared when the unit releases it.
module tb_mem_access;
    localparam int TO = 4;
    localparam logic [1:0] W = 2'b00, H = 2'b01, B = 2'b10;
    localparam logic [1:0] ALU = 2'b00, MEM = 2'b01, PC4 = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEMWr_in, loadSignExt_in, RFWr_in, dm_ack;
    logic [1:0]  MEMOp_in, mux_WBData_in;
    logic [4:0]  WBSel_in;
    logic [31:0] addr_in, store_data_in, pc_plus4_in, dm_rdata;
    logic        dm_req, dm_we, stall, wb_RFWr, addr_err, bus_err;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, wb_data;
    logic [4:0]  wb_sel;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  sel;
        logic        rfwr;
        logic        berr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    mem_access #(.ACK_TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .MEMWr_in(MEMWr_in), .MEMOp_in(MEMOp_in), .loadSignExt_in(loadSignExt_in),
        .mux_WBData_in(mux_WBData_in), .WBSel_in(WBSel_in), .RFWr_in(RFWr_in),
        .addr_in(addr_in), .store_data_in(store_data_in), .pc_plus4_in(pc_plus4_in),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall(stall),
        .wb_data(wb_data), .wb_sel(wb_sel), .wb_RFWr(wb_RFWr),
        .addr_err(addr_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Drive one instruction, play the memory (ack on cycle ack_lat, -1 = never),
    // then pop and compare the WB result when stall drops.
    task automatic run(input string tag, input logic mw, input logic [1:0] op,
                       input logic sx, input logic [1:0] wbm, input logic [4:0] sel,
                       input logic rfwr, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [31:0] pc, input logic [31:0] rdata, input int ack_lat,
                       input logic e_req, input logic [3:0] e_be, input logic [31:0] e_wdata,
                       input logic e_aerr, input int e_stalls, input logic [31:0] e_data,
                       input logic e_rfwr, input logic e_berr);
        exp_t e;
        exp_t got;
        int   stalls = 0;
        logic done = 1'b0;
        MEMWr_in = mw; MEMOp_in = op; loadSignExt_in = sx; mux_WBData_in = wbm;
        WBSel_in = sel; RFWr_in = rfwr; addr_in = addr; store_data_in = sd;
        pc_plus4_in = pc; dm_rdata = rdata; dm_ack = (ack_lat == 0);
        e = '{data: e_data, sel: sel, rfwr: e_rfwr, berr: e_berr};
        sb.push_back(e);
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk({tag, "_req"}, 32'(dm_req), 32'(e_req));
                chk({tag, "_we"}, 32'(dm_we), 32'(e_req & mw));
                chk({tag, "_be"}, 32'(dm_be), 32'(e_be));
                chk({tag, "_addr"}, dm_addr, {addr[31:2], 2'b00});
                chk({tag, "_aerr"}, 32'(addr_err), 32'(e_aerr));
                if (mw) chk({tag, "_wdata"}, dm_wdata, e_wdata);
            end
            if (stall) stalls++;
            else done = 1'b1;
            @(posedge clk);
            #1;
            if (!done) dm_ack = (k + 1 == ack_lat);
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_stalls"}, stalls, e_stalls);
        got = '{data: wb_data, sel: wb_sel, rfwr: wb_RFWr, berr: bus_err};
        e = sb.pop_front();
        chk({tag, "_wbdata"}, got.data, e.data);
        chk({tag, "_wbsel"}, 32'(got.sel), 32'(e.sel));
        chk({tag, "_wbrfwr"}, 32'(got.rfwr), 32'(e.rfwr));
        chk({tag, "_buserr"}, 32'(got.berr), 32'(e.berr));
        dm_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; MEMWr_in = 1'b1; MEMOp_in = W; loadSignExt_in = 1'b0;
        mux_WBData_in = ALU; WBSel_in = '0; RFWr_in = 1'b0; addr_in = '0;
        store_data_in = '0; pc_plus4_in = '0; dm_rdata = '0; dm_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(dm_req), 0);
        chk("rst_we", 32'(dm_we), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_wbdata", wb_data, 0);
        chk("rst_wbsel", 32'(wb_sel), 0);
        chk("rst_wbrfwr", 32'(wb_RFWr), 0);
        chk("rst_buserr", 32'(bus_err), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        //   tag        mw op sx wbm  sel rf addr          sd            pc            rdata         ack  req be       wdata         ae stl data          rf be
        run("sb",       1, B, 0, ALU, 0,  0, 32'h00001003, 32'h000000A5, 0,            0,             0,  1, 4'b1000, 32'hA5A5A5A5, 0, 0, 32'h00001003, 0, 0);
        run("lh",       0, H, 1, MEM, 5,  1, 32'h00002002, 0,            0,            32'h80017FFF,  3,  1, 4'b1100, 0,            0, 3, 32'hFFFF8001, 1, 0);
        run("lbu",      0, B, 0, MEM, 6,  1, 32'h00002001, 0,            0,            32'h0000F000,  0,  1, 4'b0010, 0,            0, 0, 32'h000000F0, 1, 0);
        run("lb",       0, B, 1, MEM, 7,  1, 32'h00002001, 0,            0,            32'h0000F000,  1,  1, 4'b0010, 0,            0, 1, 32'hFFFFFFF0, 1, 0);
        run("lw_mis",   0, W, 0, MEM, 8,  1, 32'h00003002, 0,            0,            32'hDEADBEEF, -1,  0, 4'b0000, 0,            1, 0, 32'hDEADBEEF, 0, 0);
        // Timeout: issue cycle plus TO wait cycles stalled, released on the timeout cycle
        run("sw_to",    1, W, 0, ALU, 0,  0, 32'h00005004, 32'h11223344, 0,            0,            -1,  1, 4'b1111, 32'h11223344, 0, TO+1, 32'h00005004, 0, 1);
        run("addu0",    0, W, 0, ALU, 3,  1, 32'h00000077, 0,            0,            0,            -1,  0, 4'b0000, 0,            0, 0, 32'h00000077, 1, 0);
        run("lw_to",    0, W, 0, MEM, 10, 1, 32'h00005008, 0,            0,            32'hCAFEF00D, -1,  1, 4'b1111, 0,            0, TO+1, 32'hCAFEF00D, 0, 1);
        run("sh_ackto", 1, H, 0, ALU, 0,  0, 32'h00006006, 32'h0000BEEF, 0,            0,        TO+1,  1, 4'b1100, 32'hBEEFBEEF, 0, TO+1, 32'h00006006, 0, 0);
        run("addu",     0, W, 0, ALU, 9,  1, 32'h12345678, 0,            0,            0,            -1,  0, 4'b0000, 0,            0, 0, 32'h12345678, 1, 0);
        run("jal",      0, W, 0, PC4, 31, 1, 32'h00000000, 0,            32'h0040000C, 0,            -1,  0, 4'b0000, 0,            0, 0, 32'h0040000C, 1, 0);

        // Load left waiting, then reset mid-access: dropped, WB cleared
        MEMWr_in = 1'b0; MEMOp_in = W; loadSignExt_in = 1'b0; mux_WBData_in = MEM;
        WBSel_in = 5'd7; RFWr_in = 1'b1; addr_in = 32'h00004000; dm_ack = 1'b0;
        @(negedge clk);
        chk("rw_req", 32'(dm_req), 1);
        chk("rw_stall", 32'(stall), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rw_rst_req", 32'(dm_req), 0);
        chk("rw_rst_stall", 32'(stall), 0);
        @(posedge clk);
        #1;
        chk("rw_wbrfwr", 32'(wb_RFWr), 0);
        chk("rw_wbdata", wb_data, 0);
        rst = 1'b0;

        run("lhu",      0, H, 0, MEM, 12, 1, 32'h00002000, 0,            0,            32'h80017FFF,  0,  1, 4'b0011, 0,            0, 0, 32'h00007FFF, 1, 0);
        run("lb3",      0, B, 1, MEM, 13, 1, 32'h00002003, 0,            0,            32'h80017FFF,  2,  1, 4'b1000, 0,            0, 2, 32'hFFFFFF80, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
